load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage fed by the ALU: takes the ALU result as effective address plus rs2 store data.
//  Runs one load/store per request over a word-wide req/ack data-memory port.
//  Byte/half/word access with byte strobes; load sign/zero extension.
//  Returns writeback data to the pipeline; signals done, or a fault on bus timeout or misalignment.
// PARAMETERS
//  ACK_TIMEOUT  255  max cycles waiting for mem_ack before bus fault (1..255)
// PORTS
//  clk         in   1   rising-edge clock, sole clock
//  reset       in   1   synchronous, active-high
//  start       in   1   request strobe; sampled only in IDLE
//  is_store    in   1   1 = store, 0 = load
//  funct3      in   3   000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//  addr        in   32  effective address (ALU out)
//  store_data  in   32  rs2 value
//  busy        out  1   high from accepted start until done/fault cycle inclusive
//  done        out  1   1-cycle pulse, access completed OK
//  fault       out  1   1-cycle pulse, access aborted
//  fault_code  out  2   00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3
//  load_data   out  32  extended load result; held until next done
//  mem_req     out  1   memory request, held until mem_ack
//  mem_we      out  1   write enable
//  mem_addr    out  32  {addr[31:2],2'b00}
//  mem_wstrb   out  4   byte lanes for stores; 0000 for loads
//  mem_wdata   out  32  store data replicated into lanes
//  mem_rdata   in   32  read word, valid with mem_ack
//  mem_ack     in   1   1-cycle completion from memory
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0.
//  FSM IDLE -> REQ -> RESP -> IDLE; FAULT is a 1-cycle state before returning to IDLE.
//  IDLE & start: latch all inputs; check funct3 (011/110/111, or store with 1xx -> illegal);
//    on error go to FAULT; else REQ with mem_req=1 on the next cycle.
//  REQ: mem_* held stable; counter increments each cycle.
//    mem_ack -> RESP, capture mem_rdata.
//    Counter reaches ACK_TIMEOUT without ack -> FAULT code 10; mem_req drops.
//  RESP: done=1; load_data updated (loads only); next state IDLE.
//    Latency with ack in the first REQ cycle: start@T, done@T+3.
//  FAULT: fault=1 and fault_code for one cycle; load_data unchanged; no memory access made.
//  Lane select by addr[1:0]:
//    byte: wstrb = 0001<<a, wdata = {4{sd[7:0]}}
//    half: wstrb = 0011<<a, wdata = {2{sd[15:0]}}
//    word: wstrb = 1111
//    Load extracts the selected lane; LB/LH sign-extend, LBU/LHU zero-extend.
//  start while busy: ignored (no queueing).
//  mem_ack outside REQ: ignored.
//  reset mid-access: immediate IDLE, mem_req=0 next edge, no done/fault pulse.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    half with addr[0]=1, or word with addr[1:0]!=0 -> FAULT code 01, no memory access.
//  Undefined:
//    low offending bits forced to 0 (half: addr[0], word: addr[1:0]);
//    access proceeds aligned; code 01 never produced.
// STRUCTURE
//  Shared package lsu_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU),
//    fault_code constants, FSM state enum.
//  One sub-module lsu_lane_align (combinational):
//    store lane/strobe generation and load extract/extend.
//  Top holds FSM, input latches and timeout counter.
// TESTING
//  SW addr=0x100 sd=0xDEADBEEF, ack 1st cycle -> mem_addr=0x100 wstrb=1111 wdata=DEADBEEF,
//    done at start+3.
//  SB addr=0x103 sd=0x000000A5 -> wstrb=1000 wdata=A5A5A5A5.
//  LB addr=0x102, rdata=0x12805634 -> load_data=0xFFFFFF80;
//    LBU same -> 0x00000080; LH addr=0x102 -> 0x00001280.
//  No ack for ACK_TIMEOUT cycles -> fault=1 code 10, mem_req low, busy low next cycle.
//  LW addr=0x101:
//    with MISALIGN_TRAP_EN -> fault code 01, mem_req never asserted;
//    without -> mem_addr=0x100, done.
//  reset asserted during REQ -> mem_req=0 after edge, no done; new start then completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings,
// fault codes, FSM state type and the illegal-funct3 helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Unsigned variants exist only for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic st);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
               (st && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the load/store unit (combinational).
// Ports: funct3/offset select the lane; store_data -> wstrb/wdata,
// rdata -> ldata (sign/zero extended).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        ldata = rdata;
        case (funct3)
            F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ldata = {24'b0, shifted[7:0]};
            F3_H:    ldata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ldata = {16'b0, shifted[15:0]};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one access per start over a req/ack
// word port, with byte strobes, load extension and fault reporting.
// Ports: clk/reset (sync, active-high); start/is_store/funct3/addr/
// store_data request; busy/done/fault/fault_code/load_data status;
// mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata/mem_rdata/mem_ack bus.
// Option: define MISALIGN_TRAP_EN to fault on misaligned half/word
// accesses; otherwise the offending low address bits are cleared.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] sd_q;
    logic [31:0] rdata_q;
    logic [7:0]  cnt;
    logic        req_q;
    logic        done_q;
    logic        fault_q;
    logic [1:0]  code_q;
    logic [1:0]  pend_code;
    logic [31:0] load_q;

    logic [31:0] addr_al;
    logic        accept;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] ldata;

    // A pulse cycle still counts as busy, so a start there is dropped.
    assign accept = start && (state == ST_IDLE) && !done_q && !fault_q;

    always_comb begin
        addr_al = addr;
        case (funct3[1:0])
            2'b01:   addr_al = {addr[31:1], 1'b0};
            2'b10:   addr_al = {addr[31:2], 2'b00};
            default: addr_al = addr;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`endif

    lsu_lane_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .store_data (sd_q),
        .rdata      (rdata_q),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .ldata      (ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            st_q      <= 1'b0;
            f3_q      <= 3'b0;
            addr_q    <= 32'b0;
            sd_q      <= 32'b0;
            rdata_q   <= 32'b0;
            cnt       <= 8'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= FC_NONE;
            pend_code <= FC_NONE;
            load_q    <= 32'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        st_q   <= is_store;
                        f3_q   <= funct3;
                        addr_q <= addr_al;
                        sd_q   <= store_data;
                        cnt    <= 8'b0;
                        if (f3_illegal(funct3, is_store)) begin
                            pend_code <= FC_ILLEGAL;
                            state     <= ST_FAULT;
`ifdef MISALIGN_TRAP_EN
                        end else if (misaligned) begin
                            pend_code <= FC_MISALIGN;
                            state     <= ST_FAULT;
`endif
                        end else begin
                            req_q <= 1'b1;
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        req_q   <= 1'b0;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == TO_LAST) begin
                            req_q     <= 1'b0;
                            pend_code <= FC_TIMEOUT;
                            state     <= ST_FAULT;
                        end
                    end
                end
                ST_RESP: begin
                    done_q <= 1'b1;
                    if (!st_q) begin
                        load_q <= ldata;
                    end
                    state <= ST_IDLE;
                end
                ST_FAULT: begin
                    fault_q <= 1'b1;
                    code_q  <= pend_code;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state != ST_IDLE) || done_q || fault_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign load_data  = load_q;
    assign mem_req    = req_q;
    assign mem_we     = req_q && st_q;
    assign mem_addr   = req_q ? {addr_q[31:2], 2'b00} : 32'b0;
    assign mem_wstrb  = (req_q && st_q) ? wstrb : 4'b0;
    assign mem_wdata  = (req_q && st_q) ? wdata : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus random
// transactions checked against a byte-level reference model.
module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] store_data = 32'b0;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'b0;
    logic        mem_ack = 1'b0;

    load_store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_exp_t;

    typedef struct {
        logic        is_fault;
        logic [1:0]  code;
        logic [31:0] ldata;
    } rsp_exp_t;

    req_exp_t req_sb[$];
    rsp_exp_t rsp_sb[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] model_ld = 32'b0;
    logic req_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares bus requests and completion pulses to the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && !req_prev) begin
                chk("req_expected", 32'(req_sb.size() > 0), 32'd1);
                if (req_sb.size() > 0) begin
                    req_exp_t e;
                    e = req_sb.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
                    chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (done || fault) begin
                chk("pulse_expected", 32'(rsp_sb.size() > 0), 32'd1);
                if (rsp_sb.size() > 0) begin
                    rsp_exp_t r;
                    r = rsp_sb.pop_front();
                    chk("fault", 32'(fault), 32'(r.is_fault));
                    chk("done", 32'(done), 32'(!r.is_fault));
                    chk("fault_code", 32'(fault_code), 32'(r.code));
                    chk("load_data", load_data, r.ldata);
                end
            end
        end
        req_prev = mem_req;
    end

    // Reference model + driver for one transaction. dly = REQ cycles
    // before ack; dly >= TO means the memory never answers.
    task automatic run_txn(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int dly,
                           input bit poke, output int lat);
        int bytes;
        int off;
        logic [31:0] ea;
        logic [31:0] mask;
        logic [31:0] v;
        bit illegal;
        bit access;
        bit seen;
        req_exp_t q;
        rsp_exp_t r;

        illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && f3 >= 4);
        bytes = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        ea = a - (a % bytes);
        off = int'(ea % 4);
        r.is_fault = 1'b0;
        r.code = 2'b00;
        r.ldata = model_ld;
        q.addr = (ea / 4) * 4;
        q.we = st;
        q.strb = 4'b0;
        q.wdata = 32'b0;
        access = 1'b0;
        if (illegal) begin
            r.is_fault = 1'b1;
            r.code = 2'b11;
`ifdef MISALIGN_TRAP_EN
        end else if ((a % bytes) != 0) begin
            r.is_fault = 1'b1;
            r.code = 2'b01;
`endif
        end else begin
            access = 1'b1;
            if (st) begin
                q.strb = 4'(((1 << bytes) - 1) << off);
                if (bytes == 1) q.wdata = {24'b0, sd[7:0]} * 32'h01010101;
                else if (bytes == 2) q.wdata = {16'b0, sd[15:0]} * 32'h00010001;
                else q.wdata = sd;
            end
            if (dly >= TO) begin
                r.is_fault = 1'b1;
                r.code = 2'b10;
            end else if (!st) begin
                mask = (bytes == 4) ? 32'hFFFFFFFF : 32'((1 << (8 * bytes)) - 1);
                v = (rd >> (8 * off)) & mask;
                if (f3 < 4 && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
                r.ldata = v;
            end
        end
        model_ld = r.ldata;
        if (access) req_sb.push_back(q);
        rsp_sb.push_back(r);

        is_store = st;
        funct3 = f3;
        addr = a;
        store_data = sd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        addr = $urandom;
        store_data = $urandom;
        funct3 = 3'($urandom);
        is_store = 1'($urandom);
        seen = 1'b0;
        lat = 0;
        for (int k = 1; k <= TO + 12; k++) begin
            if (done || fault) begin
                seen = 1'b1;
                lat = k;
                break;
            end
            if (access && k - 1 == dly && dly < TO) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack = (!access && k == 1) ? 1'($urandom) : 1'b0;
                mem_rdata = $urandom;
            end
            start = (poke && k == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        mem_ack = 1'b0;
        chk("completion_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("busy_on_pulse", 32'(busy), 32'd1);
            chk("req_low_on_pulse", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
            chk("busy_after_pulse", 32'(busy), 32'd0);
        end else begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            req_sb.delete();
            rsp_sb.delete();
            model_ld = 32'b0;
        end
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_code", 32'(fault_code), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0, lat);
        chk("sw_latency", 32'(lat), 32'd3);
        run_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 1'b1, lat);
        run_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h12805634, 0, 1'b0, lat);
        chk("lb_value", load_data, 32'hFFFFFF80);
        run_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h12805634, 2, 1'b0, lat);
        chk("lbu_value", load_data, 32'h00000080);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h12805634, 0, 1'b1, lat);
        chk("lh_value", load_data, 32'h00001280);
        run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, TO, 1'b0, lat);
        run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 1, 1'b0, lat);
        run_txn(1'b0, 3'b011, 32'h104, 32'h0, 32'h0, 0, 1'b0, lat);
        run_txn(1'b1, 3'b100, 32'h104, 32'h11, 32'h0, 0, 1'b0, lat);

        // Reset while a load waits for ack: no pulse, bus idle after edge.
        req_sb.push_back('{addr: 32'h200, we: 1'b0, strb: 4'b0, wdata: 32'b0});
        is_store = 1'b0;
        funct3 = 3'b010;
        addr = 32'h200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("req_before_reset", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("req_after_reset", 32'(mem_req), 32'd0);
        chk("busy_after_reset", 32'(busy), 32'd0);
        chk("done_after_reset", 32'(done), 32'd0);
        reset = 1'b0;
        model_ld = 32'b0;
        @(posedge clk); #1;
        run_txn(1'b0, 3'b010, 32'h204, 32'h0, 32'h89ABCDEF, 0, 1'b0, lat);
        chk("post_reset_lw", load_data, 32'h89ABCDEF);

        for (int i = 0; i < 300; i++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom,
                    $urandom, d, 1'($urandom), lat);
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("req_queue_drained", 32'(req_sb.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
